// File: rtl/io_led_bank_if.sv
// Per-channel CPU I/O bus bundle: address, write data/strobe, read strobe, read data and ready.
interface io_led_bank_if #(
    parameter int NCH = 4
);
    logic [NCH*32-1:0] IOaddr;
    logic [NCH*32-1:0] OutData;
    logic [NCH-1:0]    OutStrobe;
    logic [NCH-1:0]    InStrobe;
    logic [NCH*32-1:0] InData;
    logic [NCH-1:0]    InRdy;

    modport master (
        output IOaddr, OutData, OutStrobe, InStrobe,
        input  InData, InRdy
    );

    modport slave (
        input  IOaddr, OutData, OutStrobe, InStrobe,
        output InData, InRdy
    );
endinterface

// File: rtl/io_led_bank.sv
// Per-channel output register bank with static/blink/PWM modes and register readback.
// Bank follows register state one cycle later; reads take one WAIT cycle (InRdy low), strobes in WAIT are dropped.
module io_led_bank #(
    parameter int          NCH       = 4,
    parameter int          WIDTH     = 8,
    parameter int          DIV_W     = 24,
    parameter logic [31:0] ADDR_BASE = 32'h0000_03F0
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    io_led_bank_if.slave         bus,
    output logic [NCH*WIDTH-1:0] bank
);

    localparam logic [31:0] ADDR_DATA   = ADDR_BASE + 32'hF;
    localparam logic [31:0] ADDR_MODE   = ADDR_BASE + 32'hE;
    localparam logic [31:0] ADDR_PERIOD = ADDR_BASE + 32'hD;

    typedef enum logic {
        RD_IDLE,
        RD_WAIT
    } rd_state_t;

    logic [WIDTH-1:0] bank_arr   [NCH];
    logic [31:0]      indata_arr [NCH];
    logic             rdy_arr    [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [31:0]      addr;
        logic [31:0]      wdat;
        logic             wr_data, wr_mode, wr_per;
        logic [WIDTH-1:0] data_q;
        logic [1:0]       mode_q;
        logic [DIV_W-1:0] period_q;
        logic [DIV_W-1:0] blink_cnt;
        logic             phase;
        logic [7:0]       pwm_cnt;
        logic [WIDTH-1:0] bank_nxt, bank_q;
        logic [31:0]      rd_val, indata_q;
        rd_state_t        rd_q, rd_d;
        logic             rd_cap;

        assign addr    = bus.IOaddr[32*k +: 32];
        assign wdat    = bus.OutData[32*k +: 32];
        assign wr_data = bus.OutStrobe[k] && (addr == ADDR_DATA);
        assign wr_mode = bus.OutStrobe[k] && (addr == ADDR_MODE);
        assign wr_per  = bus.OutStrobe[k] && (addr == ADDR_PERIOD);

        always_ff @(posedge clk or negedge Reset_n) begin
            if (!Reset_n) begin
                data_q    <= '0;
                mode_q    <= '0;
                period_q  <= '0;
                blink_cnt <= '0;
                phase     <= 1'b1;
                pwm_cnt   <= '0;
            end else begin
                if (wr_data) data_q   <= wdat[WIDTH-1:0];
                if (wr_mode) mode_q   <= wdat[1:0];
                if (wr_per)  period_q <= wdat[DIV_W-1:0];
                // Mode/period changes restart both generators so the new pattern begins cleanly.
                if (wr_mode || wr_per) begin
                    blink_cnt <= wr_per ? wdat[DIV_W-1:0] : period_q;
                    phase     <= 1'b1;
                    pwm_cnt   <= '0;
                end else begin
                    pwm_cnt <= pwm_cnt + 8'd1;
                    if (mode_q == 2'd1) begin
                        if (blink_cnt == '0) begin
                            blink_cnt <= period_q;
                            if (period_q != '0) phase <= ~phase;
                        end else begin
                            blink_cnt <= blink_cnt - DIV_W'(1);
                        end
                    end
                end
            end
        end

        always_comb begin
            bank_nxt = data_q;
            case (mode_q)
                2'd1:    bank_nxt = data_q & {WIDTH{phase}};
                2'd2:    bank_nxt = (pwm_cnt < period_q[7:0]) ? data_q : '0;
                default: bank_nxt = data_q;
            endcase
        end

        always_ff @(posedge clk or negedge Reset_n) begin
            if (!Reset_n) bank_q <= '0;
            else          bank_q <= bank_nxt;
        end

        always_comb begin
            rd_val = '0;
            if (addr == ADDR_DATA)        rd_val[WIDTH-1:0] = data_q;
            else if (addr == ADDR_MODE)   rd_val[1:0]       = mode_q;
            else if (addr == ADDR_PERIOD) rd_val[DIV_W-1:0] = period_q;
        end

        always_comb begin
            rd_d   = rd_q;
            rd_cap = 1'b0;
            case (rd_q)
                RD_IDLE: if (bus.InStrobe[k]) begin
                    rd_d   = RD_WAIT;
                    rd_cap = 1'b1;
                end
                RD_WAIT: rd_d = RD_IDLE;
                default: rd_d = RD_IDLE;
            endcase
        end

        // Capture uses pre-edge register values, so a same-edge write is not visible to this read.
        always_ff @(posedge clk or negedge Reset_n) begin
            if (!Reset_n) begin
                rd_q     <= RD_IDLE;
                indata_q <= '0;
            end else begin
                rd_q <= rd_d;
                if (rd_cap) indata_q <= rd_val;
            end
        end

        assign bank_arr[k]   = bank_q;
        assign indata_arr[k] = indata_q;
        assign rdy_arr[k]    = (rd_q == RD_IDLE);
    end

    always_comb begin
        bank       = '0;
        bus.InData = '0;
        bus.InRdy  = '0;
        for (int i = 0; i < NCH; i++) begin
            bank[WIDTH*i +: WIDTH] = bank_arr[i];
            bus.InData[32*i +: 32] = indata_arr[i];
            bus.InRdy[i]           = rdy_arr[i];
        end
    end

endmodule

// File: tb/tb_io_led_bank.sv
// Directed bench for io_led_bank: static, blink, PWM, readback, same-edge access and async reset.
module tb_io_led_bank;
    localparam int NCH = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    logic [NCH*WIDTH-1:0] bank;
    int errors = 0;
    int checks = 0;

    io_led_bank_if #(.NCH(NCH)) bus ();

    io_led_bank #(.NCH(NCH), .WIDTH(WIDTH), .DIV_W(24), .ADDR_BASE(32'h0000_03F0)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus),
        .bank    (bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.IOaddr[ch*32 +: 32]  = a;
        bus.OutData[ch*32 +: 32] = d;
        bus.OutStrobe[ch]        = 1'b1;
        @(negedge clk);
        bus.OutStrobe[ch] = 1'b0;
    endtask

    // Returns at the negedge inside the WAIT cycle.
    task automatic rd(input int ch, input logic [31:0] a);
        @(negedge clk);
        bus.IOaddr[ch*32 +: 32] = a;
        bus.InStrobe[ch]        = 1'b1;
        @(negedge clk);
        bus.InStrobe[ch] = 1'b0;
    endtask

    task automatic count_on(input int ch, input logic [7:0] val, output int cnt);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bank[ch*8 +: 8] == val) cnt++;
        end
    endtask

    initial begin
        int cnt;
        logic [7:0] exp8;
        bus.IOaddr    = '0;
        bus.OutData   = '0;
        bus.OutStrobe = '0;
        bus.InStrobe  = '0;

        // Reset state
        #12;
        check("reset_bank", bank, 32'h0);
        check("reset_rdy", 32'(bus.InRdy), 32'hF);
        check("reset_indata0", bus.InData[31:0], 32'h0);
        @(negedge clk);
        Reset_n = 1'b1;

        // Static write on ch0
        wr(0, 32'h3FF, 32'hA5);
        @(negedge clk);
        check("static_ch0", 32'(bank[7:0]), 32'hA5);
        check("static_others", 32'(bank[31:8]), 32'h0);

        // Blink on ch1, period 3 -> 4-cycle half period
        wr(1, 32'h3FF, 32'hFF);
        wr(1, 32'h3FD, 32'd3);
        wr(1, 32'h3FE, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp8 = (((i - 1) / 4) % 2 == 0) ? 8'hFF : 8'h00;
            check($sformatf("blink_c%0d", i), 32'(bank[15:8]), 32'(exp8));
        end
        check("blink_ch0_hold", 32'(bank[7:0]), 32'hA5);

        // PWM on ch2
        wr(2, 32'h3FF, 32'h0F);
        wr(2, 32'h3FD, 32'd64);
        wr(2, 32'h3FE, 32'd2);
        @(negedge clk);
        count_on(2, 8'h0F, cnt);
        check("pwm_duty64", cnt, 32'd64);
        wr(2, 32'h3FD, 32'd0);
        @(negedge clk);
        count_on(2, 8'h0F, cnt);
        check("pwm_duty0", cnt, 32'd0);
        wr(2, 32'h3FD, 32'd255);
        @(negedge clk);
        count_on(2, 8'h0F, cnt);
        check("pwm_duty255", cnt, 32'd255);

        // Readback with handshake; strobe held during WAIT must be ignored
        wr(0, 32'h3FF, 32'h3C);
        @(negedge clk);
        check("rd_idle_rdy", 32'(bus.InRdy[0]), 32'h1);
        bus.IOaddr[31:0] = 32'h3FF;
        bus.InStrobe[0]  = 1'b1;
        @(negedge clk);
        check("rd_wait_rdy", 32'(bus.InRdy[0]), 32'h0);
        check("rd_data", bus.InData[31:0], 32'h3C);
        bus.IOaddr[31:0] = 32'h3FE;
        @(negedge clk);
        bus.InStrobe[0] = 1'b0;
        check("rd_back_rdy", 32'(bus.InRdy[0]), 32'h1);
        check("rd_wait_ignored", bus.InData[31:0], 32'h3C);
        rd(0, 32'h400);
        check("rd_unmapped", bus.InData[31:0], 32'h0);
        rd(1, 32'h3FE);
        check("rd_mode_ch1", bus.InData[63:32], 32'h1);
        rd(1, 32'h3FD);
        check("rd_period_ch1", bus.InData[63:32], 32'h3);
        rd(2, 32'h3FD);
        check("rd_period_ch2", bus.InData[95:64], 32'hFF);

        // Same-edge write and read
        wr(0, 32'h3FF, 32'h22);
        @(negedge clk);
        bus.IOaddr[31:0]  = 32'h3FF;
        bus.OutData[31:0] = 32'h11;
        bus.OutStrobe[0]  = 1'b1;
        bus.InStrobe[0]   = 1'b1;
        @(negedge clk);
        bus.OutStrobe[0] = 1'b0;
        bus.InStrobe[0]  = 1'b0;
        check("same_edge_rd", bus.InData[31:0], 32'h22);
        @(negedge clk);
        check("same_edge_bank", 32'(bank[7:0]), 32'h11);

        // Async reset mid-blink and mid-read
        rd(0, 32'h3FF);
        check("pre_rst_rdy", 32'(bus.InRdy[0]), 32'h0);
        check("pre_rst_data", bus.InData[31:0], 32'h11);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_bank", bank, 32'h0);
        check("rst_rdy", 32'(bus.InRdy), 32'hF);
        check("rst_indata0", bus.InData[31:0], 32'h0);
        @(negedge clk);
        Reset_n = 1'b1;
        rd(1, 32'h3FE);
        check("post_rst_mode", bus.InData[63:32], 32'h0);
        @(negedge clk);
        check("post_rst_bank", bank, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
